// File: rtl/fetch_buffer.sv
// fetch_buffer: owns the fetch PC and issues in-order requests to the
// instruction memory. Returned instructions are queued for IF/ID. A redirect
// flushes the queue and drops any responses still in flight.
module fetch_buffer #(
  parameter int unsigned          DEPTH     = 4,
  parameter int unsigned          ADDR_LEN  = 32,
  parameter int unsigned          INSTR_LEN = 32,
  parameter logic [ADDR_LEN-1:0]  RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [ADDR_LEN-1:0]  redirect_pc,
  output logic                 imem_req,
  output logic [ADDR_LEN-1:0]  imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic                 out_valid,
  output logic [INSTR_LEN-1:0] out_inst,
  output logic [ADDR_LEN-1:0]  out_pc_plus_4,
  input  logic                 out_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [ADDR_LEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        tag_rd_q, tag_rd_d;
  logic [PW-1:0]        tag_wr_q, tag_wr_d;
  logic [INSTR_LEN-1:0] fifo_inst_q [DEPTH];
  logic [INSTR_LEN-1:0] fifo_inst_d [DEPTH];
  logic [ADDR_LEN-1:0]  fifo_pc4_q  [DEPTH];
  logic [ADDR_LEN-1:0]  fifo_pc4_d  [DEPTH];
  logic [ADDR_LEN-1:0]  tag_q       [DEPTH];
  logic [ADDR_LEN-1:0]  tag_d       [DEPTH];

  logic credit_ok;
  logic accept;
  logic resp;
  logic drop_resp;
  logic push;
  logic pop;

  // Handshake decode: credit covers in-flight requests plus queued entries
  always_comb begin
    credit_ok = (({1'b0, outstanding_q} + {1'b0, count_q}) < (CW + 1)'(DEPTH));
    imem_req  = !rst && !redirect_valid && credit_ok;
    accept    = imem_req && imem_ready;
    // A response with nothing outstanding is a protocol error and is ignored
    resp      = imem_rvalid && (outstanding_q != '0);
    drop_resp = resp && (redirect_valid || (drop_cnt_q != '0));
    push      = resp && !drop_resp;
    pop       = (count_q != '0) && out_ready && !redirect_valid;
  end

  // Next-state for PC, counters, tag queue and instruction FIFO
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;
    fifo_inst_d   = fifo_inst_q;
    fifo_pc4_d    = fifo_pc4_q;
    tag_d         = tag_q;

    if (accept) begin
      fetch_pc_d      = fetch_pc_q + ADDR_LEN'(4);
      tag_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d        = tag_wr_q + PW'(1);
    end

    // Tags pop with every counted response, dropped or not, to stay aligned
    if (resp) begin
      tag_rd_d = tag_rd_q + PW'(1);
    end

    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc & ~ADDR_LEN'(3);
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = outstanding_q - CW'(resp);
      drop_cnt_d    = outstanding_q - CW'(resp);
    end else begin
      outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
      if (resp && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        fifo_inst_d[wr_ptr_q] = imem_rdata;
        fifo_pc4_d[wr_ptr_q]  = tag_q[tag_rd_q] + ADDR_LEN'(4);
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc4_q[i]  <= '0;
        tag_q[i]       <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
      fifo_inst_q   <= fifo_inst_d;
      fifo_pc4_q    <= fifo_pc4_d;
      tag_q         <= tag_d;
    end
  end

  // Outputs come straight from registers: no path from imem_rdata
  always_comb begin
    imem_addr     = fetch_pc_q;
    out_valid     = (count_q != '0);
    out_inst      = fifo_inst_q[rd_ptr_q];
    out_pc_plus_4 = fifo_pc4_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer with a behavioural
// fixed-latency instruction memory returning the address as the instruction.
module tb_fetch_buffer;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mem_ent_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_ent_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc_plus_4;
  logic        out_ready;

  mem_ent_t    memq[$];
  exp_ent_t    exp_q[$];
  logic [31:0] model_pc;
  int unsigned cyc;
  int unsigned lat;
  int unsigned n_pop;
  int unsigned n_acc;
  logic [31:0] last_inst;
  logic [31:0] last_pc4;
  int unsigned n_cmp;
  int unsigned n_mis;

  fetch_buffer #(
    .DEPTH     (4),
    .ADDR_LEN  (32),
    .INSTR_LEN (32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc_plus_4  (out_pc_plus_4),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit resp_due();
    return !rst && (memq.size() != 0) && (memq[0].due <= cyc);
  endfunction

  // One clock cycle: present memory response, update models, cross the edge
  task automatic tick();
    mem_ent_t m;
    exp_ent_t e;
    bit       rsp;
    rsp         = resp_due();
    imem_rvalid = rsp;
    imem_rdata  = rsp ? memq[0].addr : 32'hDEAD_BEEF;
    #1;
    if (rst) begin
      exp_q.delete();
      memq.delete();
      model_pc = 32'h0000_0000;
    end else begin
      if (rsp) void'(memq.pop_front());
      if (redirect_valid) begin
        check_eq("req_on_redirect", 64'(imem_req), 64'(0));
        exp_q.delete();
        model_pc = redirect_pc & ~32'h3;
      end else begin
        if (out_valid && out_ready) begin
          check_eq("pop_has_expect", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("out_inst", 64'(out_inst), 64'(e.inst));
            check_eq("out_pc4", 64'(out_pc_plus_4), 64'(e.pc4));
            last_inst = out_inst;
            last_pc4  = out_pc_plus_4;
            n_pop++;
          end
        end
        if (imem_req && imem_ready) begin
          check_eq("imem_addr", 64'(imem_addr), 64'(model_pc));
          m.addr = model_pc;
          m.due  = cyc + lat;
          memq.push_back(m);
          e.inst = model_pc;
          e.pc4  = model_pc + 32'd4;
          exp_q.push_back(e);
          model_pc = model_pc + 32'd4;
          n_acc++;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_pop(input string tag, input int unsigned bound);
    int unsigned start;
    int unsigned k;
    start = n_pop;
    k = 0;
    while (n_pop == start && k < bound) begin
      tick();
      k++;
    end
    check_eq({tag, "_timeout"}, 64'(n_pop != start), 64'(1));
  endtask

  task automatic do_reset(input int unsigned new_lat);
    rst = 1'b1;
    tick();
    tick();
    lat = new_lat;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int unsigned p0;
    int unsigned a0;
    logic [31:0] head;
    bit          have_head;
    bit          done;

    clk = 1'b0; rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b1;
    cyc = 0; lat = 1; n_pop = 0; n_acc = 0; n_cmp = 0; n_mis = 0;
    model_pc = '0; last_inst = '0; last_pc4 = '0;
    @(negedge clk);

    // Reset state
    tick(); tick();
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_imem_req", 64'(imem_req), 64'(0));
    check_eq("rst_imem_addr", 64'(imem_addr), 64'(32'h0));
    check_eq("rst_out_inst", 64'(out_inst), 64'(0));
    check_eq("rst_out_pc4", 64'(out_pc_plus_4), 64'(0));

    // Stream at L=1: request at t, out_valid at t+2, then one per cycle
    rst = 1'b0;
    #1;
    check_eq("first_req", 64'(imem_req), 64'(1));
    tick();
    check_eq("lat_not_yet", 64'(out_valid), 64'(0));
    tick();
    check_eq("lat_valid", 64'(out_valid), 64'(1));
    check_eq("lat_inst", 64'(out_inst), 64'(32'h0));
    check_eq("lat_pc4", 64'(out_pc_plus_4), 64'(32'h4));
    p0 = n_pop;
    for (int i = 0; i < 20; i++) tick();
    check_eq("throughput", 64'(n_pop - p0), 64'(20));

    // Stall fill: exactly DEPTH requests, head holds, then drain in order
    do_reset(1);
    out_ready = 1'b0;
    a0 = n_acc;
    have_head = 1'b0;
    head = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) begin
        if (have_head) check_eq("stall_hold", 64'(out_inst), 64'(head));
        else begin head = out_inst; have_head = 1'b1; end
      end
    end
    #1;
    check_eq("stall_accepts", 64'(n_acc - a0), 64'(4));
    check_eq("stall_req_low", 64'(imem_req), 64'(0));
    out_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 4; i++) tick();
    check_eq("drain_count", 64'(n_pop - p0), 64'(4));

    // Redirect with two in flight at L=3; low target bits ignored
    do_reset(3);
    tick(); tick();
    check_eq("two_outstanding", 64'(memq.size()), 64'(2));
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("redir_valid_low", 64'(out_valid), 64'(0));
    check_eq("redir_req", 64'(imem_req), 64'(1));
    check_eq("redir_addr", 64'(imem_addr), 64'(32'h100));
    run_until_pop("redir", 20);
    check_eq("redir_first_inst", 64'(last_inst), 64'(32'h100));
    check_eq("redir_first_pc4", 64'(last_pc4), 64'(32'h104));

    // Redirect colliding with rvalid, pop and a ready memory
    for (int i = 0; i < 6; i++) tick();
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (resp_due() && out_valid && out_ready) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        done = 1'b1;
      end else tick();
    end
    check_eq("collide_found", 64'(done), 64'(1));
    check_eq("collide_valid_low", 64'(out_valid), 64'(0));
    run_until_pop("collide", 20);
    check_eq("collide_first", 64'(last_inst), 64'(32'h200));

    // Back-to-back redirects: the second target wins
    for (int i = 0; i < 5; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_pc = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0;
    run_until_pop("b2b", 20);
    check_eq("b2b_first", 64'(last_inst), 64'(32'h400));

    // Address wrap-around
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    run_until_pop("wrap0", 20);
    check_eq("wrap0_inst", 64'(last_inst), 64'(32'hFFFF_FFF8));
    run_until_pop("wrap1", 20);
    check_eq("wrap1_inst", 64'(last_inst), 64'(32'hFFFF_FFFC));
    check_eq("wrap1_pc4", 64'(last_pc4), 64'(32'h0));
    run_until_pop("wrap2", 20);
    check_eq("wrap2_inst", 64'(last_inst), 64'(32'h0));

    // Reset in the middle of traffic
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    #1;
    check_eq("midrst_valid", 64'(out_valid), 64'(0));
    check_eq("midrst_req", 64'(imem_req), 64'(0));
    check_eq("midrst_addr", 64'(imem_addr), 64'(32'h0));
    rst = 1'b0;
    run_until_pop("midrst", 20);
    check_eq("midrst_first", 64'(last_inst), 64'(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
